// File: rtl/bus_arb_pkg.sv
// Shared definitions for the three-requester mux arbiter family.
package bus_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Mux select value that routes the default (no source) input.
  localparam logic [1:0] SEL_NONE = 2'b11;

  localparam int unsigned NUM_REQ = 3;

endpackage

// File: rtl/bus_arbiter3_rr_pick3.sv
// Combinational round-robin picker over three requests.
// Scans ptr, ptr+1, ptr+2 (mod 3) and returns the first set request.
module rr_pick3
  import bus_arb_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] ptr,
  output logic       valid,
  output logic [1:0] idx
);

  logic [1:0] base;

  // An out-of-range pointer (3) is treated as 0 so the scan stays well defined.
  always_comb begin
    base = (ptr == 2'd3) ? 2'd0 : ptr;
  end

  // First set request in rotating priority order.
  always_comb begin
    int unsigned c;
    valid = 1'b0;
    idx   = SEL_NONE;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      c = (32'(base) + k) % NUM_REQ;
      if (!valid && req[c]) begin
        valid = 1'b1;
        idx   = 2'(c);
      end
    end
  end

endmodule

// File: rtl/bus_arbiter3.sv
// Round-robin arbiter driving the select of a 3-input datapath mux.
// Request/done handshake, one idle turnaround cycle between grants,
// and forced release after MAX_HOLD consecutive grant cycles.
module bus_arbiter3 #(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned HOLD_W   = $clog2(MAX_HOLD)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] req_in,
  input  logic [2:0] done_in,
  output logic [2:0] grant_out,
  output logic [1:0] selection_out,
  output logic       busy_out,
  output logic       timeout_out
);

  import bus_arb_pkg::*;

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  state_t            state_q;
  logic [1:0]        ptr_q;
  logic [HOLD_W-1:0] cnt_q;

  logic              pick_valid;
  logic [1:0]        pick_idx;
  logic              rel_norm;
  logic              hold_last;
  logic [1:0]        next_ptr;

  rr_pick3 u_pick (
    .req   (req_in),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // Owner is the registered select; decode its release condition and successor.
  always_comb begin
    rel_norm = 1'b0;
    next_ptr = 2'd0;
    case (selection_out)
      2'd0: begin
        rel_norm = done_in[0] | ~req_in[0];
        next_ptr = 2'd1;
      end
      2'd1: begin
        rel_norm = done_in[1] | ~req_in[1];
        next_ptr = 2'd2;
      end
      2'd2: begin
        rel_norm = done_in[2] | ~req_in[2];
        next_ptr = 2'd0;
      end
      default: begin
        rel_norm = 1'b0;
        next_ptr = 2'd0;
      end
    endcase
    hold_last = (cnt_q == HOLD_LAST);
  end

  // FSM, pointer, hold counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      ptr_q         <= 2'd0;
      cnt_q         <= '0;
      grant_out     <= '0;
      selection_out <= SEL_NONE;
      busy_out      <= 1'b0;
      timeout_out   <= 1'b0;
    end else begin
      timeout_out <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pick_valid) begin
            state_q       <= GRANT;
            grant_out     <= 3'b001 << pick_idx;
            selection_out <= pick_idx;
            busy_out      <= 1'b1;
            cnt_q         <= '0;
          end
        end
        GRANT: begin
          if (rel_norm || hold_last) begin
            state_q       <= IDLE;
            grant_out     <= '0;
            selection_out <= SEL_NONE;
            busy_out      <= 1'b0;
            ptr_q         <= next_ptr;
            // A normal release in the last hold cycle is not a timeout.
            timeout_out   <= ~rel_norm;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
